// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state encoding and grant ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/lat_counter.sv
// Fixed-latency access counter: restarts on a grant and raises done during the last access cycle.
module lat_counter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // done is registered so it is high exactly while cnt_q == LAST
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (load_i) begin
      cnt_d  = '0;
      done_d = (LAST == '0);
    end else if (en_i && !done_q) begin
      cnt_d  = cnt_q + 1'b1;
      done_d = (cnt_d == LAST);
    end else if (en_i) begin
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and data requesters, runs a
// fixed-latency access, captures read data and returns a one-cycle ack.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned STRK_W = $clog2(STARVE_MAX + 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic [STRK_W-1:0] streak_q, streak_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              busy_q, busy_d;
  logic              grant_c;
  logic              if_wins_c;
  logic              lat_done;

  lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat (
    .clk    (clk),
    .rst    (rst),
    .load_i (grant_c),
    .en_i   (state_q == ACCESS),
    .done_o (lat_done)
  );

  // IF only beats a pending DM request once DM has won STARVE_MAX times in a row
  assign if_wins_c = if_req && (!dm_req || (streak_q == STRK_MAX));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    grant_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          grant_c = 1'b1;
          state_d = ACCESS;
          if (if_wins_c) begin
            gnt_d    = GNT_IF;
            we_d     = 1'b0;
            addr_d   = if_addr;
            wdata_d  = '0;
            streak_d = '0;
          end else begin
            gnt_d    = GNT_DM;
            we_d     = dm_we;
            addr_d   = dm_addr;
            wdata_d  = dm_wdata;
            if (!if_req) begin
              streak_d = '0;
            end else if (streak_q != STRK_MAX) begin
              streak_d = streak_q + 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        if (lat_done) begin
          state_d = ACK;
          if (!we_q) begin
            if (gnt_q == GNT_IF) begin
              if_rdata_d = mem_rdata;
            end else begin
              dm_rdata_d = mem_rdata;
            end
          end
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    mem_en_d = (state_d == ACCESS);
    mem_we_d = (state_d == ACCESS) && we_d;
    if_ack_d = (state_d == ACK) && (gnt_d == GNT_IF);
    dm_ack_d = (state_d == ACK) && (gnt_d == GNT_DM);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      streak_q   <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      streak_q   <= streak_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_ack    = dm_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance for most scenarios, MEM_LAT=1 for back-to-back.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;

  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_ack, dm_ack, mem_en, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

  logic        i1_req, d1_req, d1_we;
  logic [31:0] i1_addr, d1_addr, d1_wdata, m1_rdata;
  logic        i1_ack, d1_ack, m1_en, m1_we, busy1;
  logic [31:0] i1_rdata, d1_rdata, m1_addr, m1_wdata;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(i1_req), .if_addr(i1_addr), .if_ack(i1_ack), .if_rdata(i1_rdata),
    .dm_req(d1_req), .dm_we(d1_we), .dm_addr(d1_addr), .dm_wdata(d1_wdata),
    .dm_ack(d1_ack), .dm_rdata(d1_rdata),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .busy(busy1)
  );

  // Memory model for the MEM_LAT=1 instance: data is a fixed function of the address
  assign m1_rdata = m1_addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if ({mem_en, mem_we, if_ack, dm_ack, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {mem_en, mem_we, if_ack, dm_ack, busy});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_addr_wdata got=%h exp=0", {mem_addr, mem_wdata});
    end
    checks++;
    if ({if_rdata, dm_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%h exp=0", {if_rdata, dm_rdata});
    end
  endtask

  task automatic test_if_read();
    if_req = 1'b1; if_addr = 32'h0040_0000; mem_rdata = 32'h2008_0005;
    tick();
    checks++;
    if ({mem_en, mem_we, busy} !== 3'b101 || mem_addr !== 32'h0040_0000) begin
      failures++;
      $display("FAIL if_read_acc1 en/we/busy=%b addr=%h exp=101 00400000", {mem_en, mem_we, busy}, mem_addr);
    end
    tick();
    checks++;
    if (mem_en !== 1'b1 || if_ack !== 1'b0) begin
      failures++;
      $display("FAIL if_read_acc2 mem_en=%b if_ack=%b exp=1 0", mem_en, if_ack);
    end
    tick();
    checks++;
    if (if_ack !== 1'b1 || dm_ack !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL if_read_ack if_ack=%b dm_ack=%b mem_en=%b busy=%b exp=1 0 0 1", if_ack, dm_ack, mem_en, busy);
    end
    checks++;
    if (if_rdata !== 32'h2008_0005) begin
      failures++;
      $display("FAIL if_read_data got=%h exp=20080005", if_rdata);
    end
    if_req = 1'b0;
    tick();
    checks++;
    if (if_ack !== 1'b0 || busy !== 1'b0 || mem_addr !== 32'h0040_0000) begin
      failures++;
      $display("FAIL if_read_idle if_ack=%b busy=%b addr=%h exp=0 0 00400000", if_ack, busy, mem_addr);
    end
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h0040_0010;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0000; mem_rdata = 32'h1111_2222;
    tick();
    checks++;
    if (mem_addr !== 32'h1001_0000 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL simul_dm_first addr=%h we=%b exp=10010000 0", mem_addr, mem_we);
    end
    tick(); tick();
    checks++;
    if (dm_ack !== 1'b1 || if_ack !== 1'b0 || dm_rdata !== 32'h1111_2222) begin
      failures++;
      $display("FAIL simul_dm_ack dm_ack=%b if_ack=%b dm_rdata=%h exp=1 0 11112222", dm_ack, if_ack, dm_rdata);
    end
    dm_req = 1'b0; mem_rdata = 32'h3333_4444;
    tick();
    checks++;
    if (busy !== 1'b0 || mem_addr !== 32'h1001_0000) begin
      failures++;
      $display("FAIL simul_idle busy=%b addr=%h exp=0 10010000", busy, mem_addr);
    end
    tick();
    checks++;
    if (mem_addr !== 32'h0040_0010 || mem_en !== 1'b1) begin
      failures++;
      $display("FAIL simul_if_grant addr=%h en=%b exp=00400010 1", mem_addr, mem_en);
    end
    tick();
    checks++;
    if (if_ack !== 1'b0) begin
      failures++;
      $display("FAIL simul_if_early if_ack=%b exp=0", if_ack);
    end
    tick();
    checks++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h3333_4444 || dm_rdata !== 32'h1111_2222) begin
      failures++;
      $display("FAIL simul_if_ack if_ack=%b if_rdata=%h dm_rdata=%h exp=1 33334444 11112222", if_ack, if_rdata, dm_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_dm_store();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1001_0004; dm_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    checks++;
    if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h1001_0004 || mem_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL store_acc1 en/we=%b addr=%h wdata=%h exp=11 10010004 deadbeef", {mem_en, mem_we}, mem_addr, mem_wdata);
    end
    dm_addr = 32'h0; dm_wdata = 32'h0; dm_we = 1'b0;
    tick();
    checks++;
    if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h1001_0004 || mem_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL store_acc2 en/we=%b addr=%h wdata=%h exp=11 10010004 deadbeef", {mem_en, mem_we}, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if (dm_ack !== 1'b1 || {mem_en, mem_we} !== 2'b00 || dm_rdata !== 32'h1111_2222) begin
      failures++;
      $display("FAIL store_ack dm_ack=%b en/we=%b dm_rdata=%h exp=1 00 11112222", dm_ack, {mem_en, mem_we}, dm_rdata);
    end
    dm_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    int n = 0;
    int last = 0;
    int seq [6];
    int exp_seq [6] = '{1, 1, 1, 1, 0, 1};
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_2000;
    if_req = 1'b1; if_addr = 32'h0000_3000; mem_rdata = 32'h7777_0000;
    for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
      tick();
      if (if_ack || dm_ack) begin
        seq[n] = if_ack ? 0 : 1;
        if (n > 0) begin
          checks++;
          if (cyc - last !== 4) begin
            failures++;
            $display("FAIL starve_spacing ack%0d gap=%0d exp=4", n, cyc - last);
          end
        end
        if (if_ack) begin
          checks++;
          if (if_rdata !== 32'h7777_0000) begin
            failures++;
            $display("FAIL starve_if_data got=%h exp=77770000", if_rdata);
          end
        end
        last = cyc;
        n++;
        if (n == 6) begin
          dm_req = 1'b0; if_req = 1'b0;
        end
      end
    end
    checks++;
    if (n !== 6) begin
      failures++;
      $display("FAIL starve_timeout acks=%0d exp=6", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (seq[i] !== exp_seq[i]) begin
        failures++;
        $display("FAIL starve_order ack%0d dm=%0d exp=%0d", i, seq[i], exp_seq[i]);
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
    for (int i = 0; i < 8 && busy; i++) tick();
    tick();
  endtask

  task automatic test_reset_mid_access();
    int spur = 0;
    if_req = 1'b1; if_addr = 32'h0000_0080; mem_rdata = 32'h9999_9999;
    tick(); tick();
    checks++;
    if (mem_en !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre mem_en=%b exp=1", mem_en);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_we, busy} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_async en/we/busy=%b exp=000", {mem_en, mem_we, busy});
    end
    if_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (if_ack || dm_ack || busy) spur++;
    end
    checks++;
    if (spur !== 0 || if_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_noack spurious=%0d if_rdata=%h exp=0 0", spur, if_rdata);
    end
    if_req = 1'b1; if_addr = 32'h0000_0100; mem_rdata = 32'h5555_AAAA;
    tick(); tick(); tick();
    checks++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h5555_AAAA) begin
      failures++;
      $display("FAIL rstmid_recover if_ack=%b if_rdata=%h exp=1 5555aaaa", if_ack, if_rdata);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    i1_req = 1'b1; i1_addr = 32'h0000_0000;
    for (int cyc = 0; cyc < 12 && second < 0; cyc++) begin
      tick();
      if (i1_ack) begin
        if (first < 0) begin
          first = cyc;
          checks++;
          if (i1_rdata !== 32'hA5A5_0000) begin
            failures++;
            $display("FAIL b2b_data0 got=%h exp=a5a50000", i1_rdata);
          end
          i1_addr = 32'h0000_0004;
        end else begin
          second = cyc;
          checks++;
          if (i1_rdata !== 32'hA5A5_0004) begin
            failures++;
            $display("FAIL b2b_data1 got=%h exp=a5a50004", i1_rdata);
          end
          i1_req = 1'b0;
        end
      end
    end
    checks++;
    if (first !== 1 || second - first !== 3) begin
      failures++;
      $display("FAIL b2b_timing first=%0d gap=%0d exp=1 3", first, second - first);
    end
    i1_req = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0;
    i1_req = 1'b0; i1_addr = '0; d1_req = 1'b0; d1_we = 1'b0; d1_addr = '0; d1_wdata = '0;
    tick(); tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_if_read();
    test_simultaneous();
    test_dm_store();
    test_starvation();
    test_reset_mid_access();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
